// File: rtl/sram_bridge_ctrl.sv
// sram_bridge_ctrl
// Memory-stage bridge from the 32-bit pipeline data port to a narrow external
// asynchronous SRAM. Each load/store is split into DATA_W/SRAM_DQ_W beats, and
// each beat is stretched to WAIT_CYCLES+1 clocks. `ready` stays low while an
// access is in flight so the pipeline freezes until the word is complete.
// DATA_W must be an integer multiple of SRAM_DQ_W.

module sram_bridge_ctrl #(
    parameter int DATA_W      = 32,
    parameter int SRAM_DQ_W   = 16,
    parameter int SRAM_ADDR_W = 18,
    parameter int WAIT_CYCLES = 2,
    parameter int BASE_ADDR   = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [DATA_W-1:0]      write_data,
    output logic [DATA_W-1:0]      read_data,
    output logic                   ready,
    inout  wire  [SRAM_DQ_W-1:0]   SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N
);

    localparam int BEATS  = DATA_W / SRAM_DQ_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WAIT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    // Terminal count of a beat, and the cycle just before it (where WE_N must
    // be scheduled to rise).
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_PEN  = WAIT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [BEAT_W-1:0] beat_cnt;
    logic              is_write;
    logic              dq_oe;
    logic [DATA_W-1:0] wr_shift;   // latched store word, beat 0 in the low slice

    logic              beat_end;
    logic              last_beat;
    logic              request;
    logic [31:0]       byte_off;
    logic [31:0]       first_word;

    assign request   = wr_en | rd_en;
    assign beat_end  = (wait_cnt == WAIT_LAST);
    assign last_beat = (beat_cnt == BEAT_LAST);

    // Pipeline byte address -> SRAM word address of beat 0 (byte lanes ignored).
    assign byte_off   = address - 32'(BASE_ADDR);
    assign first_word = (byte_off >> 2) * 32'(BEATS);

    // NOTE: ready is a pure continuous assignment, so it is a function of the
    // present state and request only; no storage can be inferred for it.
    assign ready = (state == DONE) || ((state == IDLE) && !request);

    // NOTE: the bus is only driven while a store is in ACCESS; every other
    // cycle it is released so the SRAM (or a later read) can own it.
    assign SRAM_DQ = dq_oe ? wr_shift[SRAM_DQ_W-1:0] : {SRAM_DQ_W{1'bz}};

    // Access sequencer: state, beat/wait counters and all registered SRAM strobes.
    // NOTE: every sequential target uses <= so all registers update together
    // from the values present before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            beat_cnt  <= '0;
            is_write  <= 1'b0;
            dq_oe     <= 1'b0;
            wr_shift  <= '0;
            read_data <= '0;
            SRAM_ADDR <= '0;
            SRAM_WE_N <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        // Store wins when both requests are presented.
                        is_write  <= wr_en;
                        wr_shift  <= write_data;
                        wait_cnt  <= '0;
                        beat_cnt  <= '0;
                        SRAM_ADDR <= first_word[SRAM_ADDR_W-1:0];
                        // First cycle of a beat is never its terminal one unless
                        // WAIT_CYCLES is 0, where WE_N is held low anyway.
                        SRAM_WE_N <= ~wr_en;
                        dq_oe     <= wr_en;
                        state     <= ACCESS;
                    end
                end

                ACCESS: begin
                    if (beat_end) begin
                        if (!is_write) begin
                            read_data[int'(beat_cnt)*SRAM_DQ_W +: SRAM_DQ_W] <= SRAM_DQ;
                        end
                        wait_cnt <= '0;
                        if (last_beat) begin
                            SRAM_WE_N <= 1'b1;
                            dq_oe     <= 1'b0;
                            state     <= DONE;
                        end else begin
                            beat_cnt  <= beat_cnt + 1'b1;
                            SRAM_ADDR <= SRAM_ADDR + 1'b1;
                            wr_shift  <= wr_shift >> SRAM_DQ_W;
                            SRAM_WE_N <= ~is_write;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        // Raise WE_N for the coming terminal cycle: one rising
                        // edge per beat latches the data into the SRAM.
                        SRAM_WE_N <= ~is_write | (wait_cnt == WAIT_PEN);
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_bridge_ctrl.sv
// tb_sram_bridge_ctrl
// Directed bench for sram_bridge_ctrl: a default instance (WAIT_CYCLES=2) and
// an address-controlled instance (WAIT_CYCLES=0), each with a small SRAM model.

module tb_sram_bridge_ctrl;

    logic        clk;
    logic        rst;

    logic        wr0, rd0, rdm0;
    logic [31:0] addr0, wd0, rdata0;
    logic        ready0, we0;
    logic [17:0] sa0;
    wire  [15:0] dq0;

    logic        wr1, rd1, rdm1;
    logic [31:0] addr1, wd1, rdata1;
    logic        ready1, we1;
    logic [17:0] sa1;
    wire  [15:0] dq1;

    logic [15:0] mem0 [64] = '{default: 16'h0000};
    logic [15:0] mem1 [64] = '{default: 16'h0000};

    int passed = 0;
    int failed = 0;
    int total  = 0;

    int          lat;
    logic [15:0] we_tr;
    logic [31:0] a_first, a_last;

    sram_bridge_ctrl u0 (
        .clk(clk), .rst(rst), .wr_en(wr0), .rd_en(rd0), .address(addr0),
        .write_data(wd0), .read_data(rdata0), .ready(ready0),
        .SRAM_DQ(dq0), .SRAM_ADDR(sa0), .SRAM_WE_N(we0)
    );

    sram_bridge_ctrl #(.WAIT_CYCLES(0)) u1 (
        .clk(clk), .rst(rst), .wr_en(wr1), .rd_en(rd1), .address(addr1),
        .write_data(wd1), .read_data(rdata1), .ready(ready1),
        .SRAM_DQ(dq1), .SRAM_ADDR(sa1), .SRAM_WE_N(we1)
    );

    // A released bus floats high, so "bus released" is observed as 16'hFFFF.
    pullup pu0 (dq0);
    pullup pu1 (dq1);

    // SRAM models: drive data during bench-flagged reads, capture while WE_N low.
    assign dq0 = rdm0 ? mem0[sa0[5:0]] : 16'bz;
    assign dq1 = rdm1 ? mem1[sa1[5:0]] : 16'bz;

    always @(negedge clk) if (we0 === 1'b0) mem0[sa0[5:0]] <= dq0;
    always @(negedge clk) if (we1 === 1'b0) mem1[sa1[5:0]] <= dq1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Present a request from just after a rising edge (cycle 0), follow it to
    // ready, then drop it after the edge that leaves DONE.
    task automatic access0(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                           output int l, output logic [15:0] wt,
                           output logic [31:0] af, output logic [31:0] al);
        wr0 = w; rd0 = r; addr0 = a; wd0 = d; rdm0 = r & ~w;
        l = -1; wt = '0; af = '0; al = '0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            wt[c] = we0;
            if (c == 1) af = 32'(sa0);
            if (ready0) begin
                l = c;
                break;
            end
            al = 32'(sa0);
        end
        @(posedge clk); #1;
        wr0 = 1'b0; rd0 = 1'b0; rdm0 = 1'b0;
    endtask

    task automatic access1(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                           output int l, output logic [15:0] wt);
        wr1 = w; rd1 = r; addr1 = a; wd1 = d; rdm1 = r & ~w;
        l = -1; wt = '0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            wt[c] = we1;
            if (ready1) begin
                l = c;
                break;
            end
        end
        @(posedge clk); #1;
        wr1 = 1'b0; rd1 = 1'b0; rdm1 = 1'b0;
    endtask

    initial begin
        wr0 = 0; rd0 = 0; rdm0 = 0; addr0 = '0; wd0 = '0;
        wr1 = 0; rd1 = 0; rdm1 = 0; addr1 = '0; wd1 = '0;

        // Reset for two cycles with no request.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready",  32'(ready0), 32'd1);
        check("rst_we_n",   32'(we0),    32'd1);
        check("rst_dq_rel", 32'(dq0),    32'h0000_FFFF);
        check("rst_rdata",  rdata0,      32'h0);
        check("rst_addr",   32'(sa0),    32'd0);
        @(posedge clk); #1;

        // Store 0xDEADBEEF at the base address: two beats of three cycles.
        access0(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, lat, we_tr, a_first, a_last);
        check("wr_latency", 32'(lat),          32'd7);
        check("wr_we_trace", 32'(we_tr[7:0]),  32'h0000_00C9);
        check("wr_mem0",    32'(mem0[0]),      32'h0000_BEEF);
        check("wr_mem1",    32'(mem0[1]),      32'h0000_DEAD);
        check("wr_rdata_hold", rdata0,         32'h0);

        // Load from 1028 (untouched words 2 and 3), then the word just stored.
        access0(1'b0, 1'b1, 32'd1028, 32'h0, lat, we_tr, a_first, a_last);
        check("rd1028_addr_b0", a_first, 32'd2);
        check("rd1028_addr_b1", a_last,  32'd3);
        check("rd1028_latency", 32'(lat), 32'd7);
        check("rd1028_data",    rdata0,  32'h0);
        access0(1'b0, 1'b1, 32'd1024, 32'h0, lat, we_tr, a_first, a_last);
        check("rd1024_latency", 32'(lat), 32'd7);
        check("rd1024_data",    rdata0,  32'hDEADBEEF);
        @(negedge clk);
        check("idle_addr_hold", 32'(sa0), 32'd1);
        @(posedge clk); #1;

        // Address-controlled instance: store then load at 1032 (words 4 and 5).
        access1(1'b1, 1'b0, 32'd1032, 32'h12345678, lat, we_tr);
        check("w0_wr_latency", 32'(lat),         32'd3);
        check("w0_we_trace",   32'(we_tr[3:0]),  32'h9);
        check("w0_mem4",       32'(mem1[4]),     32'h0000_5678);
        check("w0_mem5",       32'(mem1[5]),     32'h0000_1234);
        access1(1'b0, 1'b1, 32'd1032, 32'h0, lat, we_tr);
        check("w0_rd_latency", 32'(lat), 32'd3);
        check("w0_rd_data",    rdata1,   32'h12345678);

        // Both requests high: the store is performed, read_data untouched.
        access0(1'b1, 1'b1, 32'd1024, 32'hCAFEF00D, lat, we_tr, a_first, a_last);
        check("both_latency", 32'(lat),     32'd7);
        check("both_mem0",    32'(mem0[0]), 32'h0000_F00D);
        check("both_mem1",    32'(mem0[1]), 32'h0000_CAFE);
        check("both_rdata",   rdata0,       32'hDEADBEEF);

        // Reset during cycle 2 of a store; beat 0 already reached the SRAM.
        wr0 = 1'b1; addr0 = 32'd1024; wd0 = 32'h11112222;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; wr0 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready",  32'(ready0), 32'd1);
        check("abort_we_n",   32'(we0),    32'd1);
        check("abort_dq_rel", 32'(dq0),    32'h0000_FFFF);
        @(posedge clk); #1;
        access0(1'b0, 1'b1, 32'd1024, 32'h0, lat, we_tr, a_first, a_last);
        check("abort_rd_latency", 32'(lat), 32'd7);
        check("abort_rd_data",    rdata0,   32'hCAFE2222);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
